// File: rtl/bomb_pkg.sv
// rtl/bomb_pkg.sv - shared board types and constants for mine placement and board logic
// Contents: default board geometry (GRID_W_DEF x GRID_H_DEF), CELLS, cell_idx_t (8-bit
// board index), place_state_t (placement FSM state encoding).
package bomb_pkg;

  localparam int GRID_W_DEF = 16;
  localparam int GRID_H_DEF = 10;
  localparam int CELLS      = GRID_W_DEF * GRID_H_DEF;

  typedef logic [7:0] cell_idx_t;

  typedef enum logic [2:0] {
    PS_IDLE  = 3'd0,
    PS_REQ   = 3'd1,
    PS_WAIT  = 3'd2,
    PS_CHECK = 3'd3,
    PS_EMIT  = 3'd4,
    PS_DONE  = 3'd5,
    PS_FAIL  = 3'd6
  } place_state_t;

endpackage

// File: rtl/bomb_placer_if.sv
// rtl/bomb_placer_if.sv - valid/ready stream carrying each newly placed mine
// Signals: bomb_valid, bomb_ready, bomb_row[3:0], bomb_col[3:0].
// Modports: master (placer drives the mine), slave (board logic accepts it).
interface bomb_placer_if;

  logic       bomb_valid;
  logic       bomb_ready;
  logic [3:0] bomb_row;
  logic [3:0] bomb_col;

  modport master (
    output bomb_valid,
    output bomb_row,
    output bomb_col,
    input  bomb_ready
  );

  modport slave (
    input  bomb_valid,
    input  bomb_row,
    input  bomb_col,
    output bomb_ready
  );

endinterface

// File: rtl/bomb_occupancy.sv
// rtl/bomb_occupancy.sv - mine occupancy bitmap with clear, set and combinational lookup
// Ports: clk, rst (async active-low), clr (wipe map), set/set_idx (mark a cell),
//   hit_idx/hit (is cell mined; out-of-range indices read as 0), map (full bitmap).
module bomb_occupancy
  import bomb_pkg::*;
#(
  parameter int NCELLS = CELLS
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              set,
  input  cell_idx_t         set_idx,
  input  cell_idx_t         hit_idx,
  output logic              hit,
  output logic [NCELLS-1:0] map
);

  // Decoded compares keep the index width independent of NCELLS.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      map <= '0;
    end else if (clr) begin
      map <= '0;
    end else if (set) begin
      for (int i = 0; i < NCELLS; i++) begin
        if (set_idx == cell_idx_t'(i)) map[i] <= 1'b1;
      end
    end
  end

  always_comb begin
    hit = 1'b0;
    for (int i = 0; i < NCELLS; i++) begin
      if (hit_idx == cell_idx_t'(i)) hit = map[i];
    end
  end

endmodule

// File: rtl/bomb_placer.sv
// rtl/bomb_placer.sv - places NUM_BOMBS distinct mines using samples from an external RNG
// Ports: clk, rst (async active-low), start (begin placement), rand_change (RNG advance
//   pulse), rand_in (RNG value), safe_idx (cell never mined), bomb (bomb_placer_if.master
//   mine stream), bomb_map (occupancy bitmap), busy, done, fail.
// Optional feature macro: SAFE_CELL_EN (safe_idx sampled at start is always rejected).
module bomb_placer
  import bomb_pkg::*;
#(
  parameter int GRID_W    = GRID_W_DEF,
  parameter int GRID_H    = GRID_H_DEF,
  parameter int NUM_BOMBS = 20,
  parameter int MAX_TRIES = 1023
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  output logic                     rand_change,
  input  cell_idx_t                rand_in,
  input  cell_idx_t                safe_idx,
  bomb_placer_if.master            bomb,
  output logic [GRID_W*GRID_H-1:0] bomb_map,
  output logic                     busy,
  output logic                     done,
  output logic                     fail
);

  localparam int NCELLS   = GRID_W * GRID_H;
  localparam int COL_BITS = $clog2(GRID_W);
  localparam int CNT_W    = $clog2(NUM_BOMBS + 1);

  localparam logic [2:0] S_IDLE  = 3'(PS_IDLE);
  localparam logic [2:0] S_REQ   = 3'(PS_REQ);
  localparam logic [2:0] S_WAIT  = 3'(PS_WAIT);
  localparam logic [2:0] S_CHECK = 3'(PS_CHECK);
  localparam logic [2:0] S_EMIT  = 3'(PS_EMIT);
  localparam logic [2:0] S_DONE  = 3'(PS_DONE);
  localparam logic [2:0] S_FAIL  = 3'(PS_FAIL);

  logic [2:0]       state;
  logic [CNT_W-1:0] count;
  logic [9:0]       tries;
  logic [3:0]       row_q;
  logic [3:0]       col_q;

  cell_idx_t  idx;
  logic       in_range;
  logic       hit;
  logic       safe_hit;
  logic       reject;
  logic       launch;
  logic       accept;
  logic [3:0] row_n;
  logic [3:0] col_n;

  assign idx = rand_in;

  // Full 8-bit compare against the board size: no modulo folding, so no bias.
  assign in_range = ({1'b0, idx} < 9'(NCELLS));

  assign launch = start && ((state == S_IDLE) || (state == S_DONE) || (state == S_FAIL));

`ifdef SAFE_CELL_EN
  cell_idx_t safe_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)        safe_q <= '0;
    else if (launch) safe_q <= safe_idx;
  end

  assign safe_hit = (idx == safe_q);
`else
  // safe_idx has no effect in this build; the AND with 0 keeps it referenced.
  assign safe_hit = 1'b0 & (idx == safe_idx);
`endif

  assign reject = !in_range || hit || safe_hit;
  assign accept = (state == S_CHECK) && !reject;

  assign row_n = 4'(idx >> COL_BITS);
  assign col_n = 4'(idx & 8'(GRID_W - 1));

  bomb_occupancy #(
    .NCELLS (NCELLS)
  ) u_occupancy (
    .clk     (clk),
    .rst     (rst),
    .clr     (launch),
    .set     (accept),
    .set_idx (idx),
    .hit_idx (idx),
    .hit     (hit),
    .map     (bomb_map)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= S_IDLE;
      count <= '0;
      tries <= '0;
      row_q <= '0;
      col_q <= '0;
    end else begin
      case (state)
        S_IDLE, S_DONE, S_FAIL: begin
          if (start) begin
            state <= S_REQ;
            count <= '0;
            tries <= '0;
          end
        end
        S_REQ: begin
          // Saturate so an accept on the last allowed sample cannot wrap the
          // counter; the next reject then sees tries == MAX_TRIES and fails.
          if (tries != 10'(MAX_TRIES)) tries <= tries + 10'd1;
          state <= S_WAIT;
        end
        S_WAIT: begin
          state <= S_CHECK;
        end
        S_CHECK: begin
          if (reject) begin
            state <= (tries == 10'(MAX_TRIES)) ? S_FAIL : S_REQ;
          end else begin
            row_q <= row_n;
            col_q <= col_n;
            count <= count + CNT_W'(1);
            state <= S_EMIT;
          end
        end
        S_EMIT: begin
          if (bomb.bomb_ready) begin
            state <= (count == CNT_W'(NUM_BOMBS)) ? S_DONE : S_REQ;
          end
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

  assign rand_change     = (state == S_REQ);
  assign bomb.bomb_valid = (state == S_EMIT);
  assign bomb.bomb_row   = row_q;
  assign bomb.bomb_col   = col_q;
  assign busy            = (state == S_REQ) || (state == S_WAIT) ||
                           (state == S_CHECK) || (state == S_EMIT);
  assign done            = (state == S_DONE);
  assign fail            = (state == S_FAIL);

endmodule

// File: tb/tb_bomb_placer.sv
// tb/tb_bomb_placer.sv - self-checking bench for bomb_placer (LCG source, scoreboard of mines)
// Build with or without SAFE_CELL_EN; expectations follow the macro.
`timescale 1ns/1ps
module tb_bomb_placer;
  import bomb_pkg::*;

`ifdef SAFE_CELL_EN
  localparam bit SAFE_ON = 1'b1;
`else
  localparam bit SAFE_ON = 1'b0;
`endif
  localparam int NUM = 20;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             start = 1'b0;
  logic             rand_change;
  logic [7:0]       rand_in;
  logic [7:0]       safe_idx = 8'd0;
  logic [CELLS-1:0] bomb_map;
  logic             busy;
  logic             done;
  logic             fail;

  bomb_placer_if bus ();

  int vectors = 0;
  int errors = 0;
  int pulses = 0;
  int last_pulses = 0;
  int handshakes = 0;
  int exp_q[$];
  int exp_p[$];
  logic [CELLS-1:0] exp_map;

  logic [7:0] rng = 8'd0;
  logic       rng_load = 1'b0;
  logic       stub = 1'b0;

  always #5 clk = ~clk;

  // RNG model: advances on every clock edge that sees rand_change high.
  always @(posedge clk) begin
    if (rng_load)         rng <= 8'd7;
    else if (rand_change) rng <= stub ? 8'd38 : 8'(rng * 8'd5 + 8'd3);
    if (rand_change) pulses <= pulses + 1;
  end
  assign rand_in = rng;

  bomb_placer dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .rand_change (rand_change),
    .rand_in     (rand_in),
    .safe_idx    (safe_idx),
    .bomb        (bus),
    .bomb_map    (bomb_map),
    .busy        (busy),
    .done        (done),
    .fail        (fail)
  );

  task automatic chk(input string tag, input int obs, input int exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
    end
  endtask

  task automatic chk_map(input string tag, input logic [CELLS-1:0] obs, input logic [CELLS-1:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h, expected %h", tag, obs, exp);
    end
  endtask

  // Expected mines for a game starting from RNG value seed: LCG y' = 5y+3 mod 256,
  // keep y < 160 that is not yet mined (and not the safe cell when enabled).
  function automatic void predict(input logic [7:0] seed, input int n, input logic [7:0] safe);
    logic [7:0] y;
    bit         used [256];
    int         p;
    y = seed;
    exp_map = '0;
    for (int k = 0; k < n; k++) begin
      p = 0;
      do begin
        y = 8'(y * 8'd5 + 8'd3);
        p++;
      end while ((y >= 8'd160 || used[y] || (SAFE_ON && y == safe)) && p < 1023);
      used[y] = 1'b1;
      exp_map[y] = 1'b1;
      exp_q.push_back(int'(y));
      exp_p.push_back(p);
    end
  endfunction

  task automatic pulse_start();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Called at a negedge where the FSM sits in REQ (w0 = negedges already spent past REQ).
  // Each sample costs REQ, WAIT, CHECK -> valid appears 3*pulses negedges later.
  task automatic take_mine(input int hold, input bit keep_ready, input int w0);
    int w;
    int ei;
    int ep;
    bit bad;
    logic [3:0] r0;
    logic [3:0] c0;
    int p0;
    w = w0;
    while (!bus.bomb_valid && w < 4000) begin
      @(negedge clk);
      w++;
    end
    if (!bus.bomb_valid) begin
      chk("valid_timeout", 0, 1);
      return;
    end
    handshakes++;
    if (exp_q.size() != 0) begin
      ei = exp_q.pop_front();
      ep = exp_p.pop_front();
    end else begin
      ei = 255;
      ep = 0;
    end
    chk("mine_row", int'(bus.bomb_row), ei >> 4);
    chk("mine_col", int'(bus.bomb_col), ei & 15);
    chk("mine_samples", pulses - last_pulses, ep);
    chk("mine_latency", w, 3 * ep);
    if (hold > 0) begin
      r0 = bus.bomb_row;
      c0 = bus.bomb_col;
      p0 = pulses;
      bad = 1'b0;
      repeat (hold) begin
        @(negedge clk);
        if (!bus.bomb_valid || bus.bomb_row !== r0 || bus.bomb_col !== c0 || pulses != p0) bad = 1'b1;
      end
      chk("hold_stable", int'(bad), 0);
    end
    bus.bomb_ready = 1'b1;
    @(negedge clk);
    bus.bomb_ready = keep_ready;
    last_pulses = pulses;
  endtask

  initial begin
    int w;
    int p_start;

    // Reset state
    bus.bomb_ready = 1'b0;
    rng_load = 1'b1;
    repeat (3) @(negedge clk);
    rng_load = 1'b0;
    chk("reset_outputs", int'({rand_change, busy, done, fail, bus.bomb_valid, bus.bomb_row, bus.bomb_col}), 0);
    chk_map("reset_map", bomb_map, '0);
    @(negedge clk);
    rst = 1'b1;

    // LCG game: first two mines, the first held unaccepted for 50 cycles.
    safe_idx = 8'd38;
    predict(8'd7, 2, 8'd38);
    last_pulses = pulses;
    pulse_start();
    take_mine(50, 1'b0, 0);
    take_mine(0, 1'b0, 0);
    exp_map = '0;
`ifdef SAFE_CELL_EN
    exp_map[154] = 1'b1;
    exp_map[5]   = 1'b1;
`else
    exp_map[38]  = 1'b1;
    exp_map[154] = 1'b1;
`endif
    chk_map("lcg_two_mines_map", bomb_map, exp_map);

    // Reset during WAIT of the third sample.
    chk("abort_in_req", int'(rand_change), 1);
    @(negedge clk);
    chk("abort_in_wait", int'({busy, rand_change}), 2);
    rst = 1'b0;
    #1;
    chk("abort_outputs", int'({rand_change, busy, done, fail, bus.bomb_valid, bus.bomb_row, bus.bomb_col}), 0);
    chk_map("abort_map", bomb_map, '0);
    rng_load = 1'b1;
    @(negedge clk);
    rng_load = 1'b0;
    rst = 1'b1;
    safe_idx = 8'd0;

    // Full game with ready held high; a start while busy must be ignored.
    predict(8'd7, NUM, 8'd0);
    handshakes = 0;
    bus.bomb_ready = 1'b1;
    last_pulses = pulses;
    pulse_start();
    for (int k = 0; k < NUM; k++) begin
      if (k == 5) begin
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("start_ignored_busy", int'(busy), 1);
        take_mine(0, 1'b1, 1);
      end else begin
        take_mine(0, 1'b1, 0);
      end
    end
    bus.bomb_ready = 1'b0;
    chk("full_handshakes", handshakes, NUM);
    chk("full_status", int'({done, busy, fail}), 4);
    chk("full_popcount", $countones(bomb_map), NUM);
    chk_map("full_map", bomb_map, exp_map);
    p_start = pulses;
    repeat (5) @(negedge clk);
    chk("done_held", int'({done, busy, rand_change}), 4);
    chk("done_no_pulses", pulses - p_start, 0);

    // Stub source: every sample is 38 -> one mine, then tries exhaust.
    stub = 1'b1;
    exp_q.push_back(38);
    exp_p.push_back(1);
    p_start = pulses;
    last_pulses = pulses;
    pulse_start();
    take_mine(0, 1'b0, 0);
    w = 0;
    while (!fail && w < 5000) begin
      @(negedge clk);
      w++;
    end
    chk("stub_status", int'({fail, busy, done, bus.bomb_valid}), 8);
    chk("stub_tries", pulses - p_start, 1023);
    exp_map = '0;
    exp_map[38] = 1'b1;
    chk_map("stub_partial_map", bomb_map, exp_map);
    pulse_start();
    chk("restart_status", int'({fail, busy, done}), 2);
    chk_map("restart_map", bomb_map, '0);

    rst = 1'b0;
    repeat (2) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
